bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter and slave decoder for the system bus. It sits directly upstream of the slave ports. It takes ownership requests from master 1 and master 2, decodes the requesting master's slave-select nibble (address bits [15:12]) and grants the bus to exactly one master. While a transfer is in progress it drives the one-hot slave enable and the datapath mux select, and it releases the bus on transfer completion, on request withdrawal, or on timeout.

## Interface
Parameters:
- N_SLAVES, 3, number of attached slaves (1..15)
- SEL_W, 4, width of slave-select field (address bits [15:12])
- TIMEOUT_CYC, 1024, maximum cycles a grant may be held before forced release

Ports:
- clk  in  1  bus clock; all logic on rising edge
- rstn  in  1  reset; synchronous, active-low
- m1_req  in  1  master 1 ownership request; held for the whole transfer
- m1_sel  in  SEL_W  master 1 target slave number; stable while m1_req is high
- m1_grant  out  1  master 1 owns bus
- m1_err  out  1  one-cycle pulse: bad select or timeout for master 1
- m2_req, m2_sel, m2_grant, m2_err: same as m1_*, for master 2
- s_ready  in  N_SLAVES  slave k-1 can accept a new transfer
- s_done  in  1  one-cycle pulse: current transfer finished
- s_en  out  N_SLAVES  one-hot slave enable; all zero when no grant
- owner  out  1  datapath mux select: 0 = master 1, 1 = master 2; holds its last value when idle
- busy  out  1  high in WAIT and GRANT states

## Operation
- Select decode:
  - sel value k with 1 ≤ k ≤ N_SLAVES targets slave index k-1.
  - sel 0 or sel > N_SLAVES is invalid.
- States:
  - IDLE: no grant; evaluates requests.
  - WAIT: winner chosen; waiting for s_ready of its target.
  - GRANT: bus owned; s_en drives the target.
  - TURN: one-cycle turnaround after every release.
- IDLE:
  - With no eligible request, stay in IDLE.
  - Winner selection: a single eligible request wins. If both are eligible, the master that did not own the bus last wins. last_owner resets to master 2, so master 1 wins the first tie.
  - Winner sel invalid: pulse that master's err, set its lockout bit, stay in IDLE.
  - Winner sel valid: go to GRANT if the target's s_ready is high, otherwise go to WAIT.
- Lockout: a master with its lockout bit set is ineligible. The bit clears when its req drops.
- WAIT:
  - Target s_ready high: go to GRANT.
  - Winner req drops: go to TURN, with no err.
  - The other master is not considered while in WAIT.
- GRANT:
  - Asserted outputs: grant, s_en[target], owner=winner.
  - The 10-bit (clog2(TIMEOUT_CYC)) hold counter increments every cycle.
  - Release on whichever occurs first:
    - s_done
    - winner req low
    - counter == TIMEOUT_CYC-1, which also pulses the winner's err and sets its lockout bit
  - On release, go to TURN and update last_owner.
- TURN: all outputs are idle; go to IDLE unconditionally.
- Simultaneous s_done and timeout in the same cycle: s_done takes priority, so no err.
- Target latch: the target index is captured when leaving IDLE. sel changes after that point are ignored.

## Timing
- Reset (rstn low at an edge):
  - State IDLE.
  - m1_grant, m2_grant, m1_err, m2_err, busy = 0.
  - s_en = 0; owner = 0.
  - Counter, lockout bits and last_owner cleared; last_owner = master 2.
  - Reset mid-GRANT drops the grant on that same edge.
- All outputs are registered.
- Request to grant:
  - Request sampled at edge e0 with target ready: grant and s_en are high after e0, a latency of 1 cycle.
  - Target not ready: grant follows 1 cycle after the edge at which s_ready is sampled high.
- Release: s_done sampled at edge e1 drops grant and s_en after e1. The next grant is high at the earliest after e1+2, because of TURN plus IDLE.
- err pulse: high for exactly one cycle, registered with the state transition that causes it.
- Timeout: grant is high for exactly TIMEOUT_CYC cycles, then drops, with err high in the cycle after the last grant cycle.

## Structure
- Shared bus package (bus_pkg):
  - state enum {IDLE, WAIT, GRANT, TURN}
  - master id enum {M1, M2}
  - SEL_W constant
  - sel-to-one-hot decode function
- Sub-module arb_timeout_ctr: clear/enable counter, parameterised by TIMEOUT_CYC, with a terminal-count output.
- Top-level integration: bus_arbiter replaces direct master-to-slave wiring in top; owner drives the address/data/handshake muxes.

## Test plan
- Basic grant: m1_req=1, m1_sel=4'b0001, s_ready=3'b111 → m1_grant and s_en=3'b001 one cycle later; s_done pulse → grant low next cycle, busy low.
- Tie fairness: m1_req and m2_req rise together after reset → M1 granted. After s_done, with both still requesting, the next grant goes to M2 three cycles after s_done, then back to M1.
- Invalid select: m2_sel=0 (and, separately, 4'hA) → m2_err pulses once, no grant. Holding req gives no retry; dropping and re-raising req with sel=2 → grant, s_en=3'b010.
- Slave not ready: m1_sel=3, s_ready[2]=0 for 20 cycles → busy=1, grant=0, m2 request ignored; s_ready[2] rises → m1_grant one cycle later.
- Timeout: TIMEOUT_CYC=16, grant held with no s_done → grant high exactly 16 cycles, then m1_err pulse; the same cycle as s_done on cycle 16 → no err.
- Reset mid-transfer: rstn low for one edge during GRANT → all outputs 0 and owner 0 after that edge; the pending request is re-granted after rstn returns high.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared arbiter states, master ids and slave-select decode.
package bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, GRANT, TURN} state_t;
  typedef enum logic {M1, M2} mid_t;
  localparam int SEL_W = 4;
  localparam int MAX_SLAVES = 15;
  function automatic logic [MAX_SLAVES-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return (sel == '0) ? '0 : MAX_SLAVES'(1) << (sel - 1'b1);
  endfunction
endpackage

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr: grant hold counter with clear/enable and terminal count.
module arb_timeout_ctr #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rstn || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = en && cnt == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter with slave-select decode and hold timeout.
module bus_arbiter #(
  parameter int N_SLAVES    = 3,
  parameter int SEL_W       = bus_pkg::SEL_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                m1_req,
  input  logic [SEL_W-1:0]    m1_sel,
  output logic                m1_grant,
  output logic                m1_err,
  input  logic                m2_req,
  input  logic [SEL_W-1:0]    m2_sel,
  output logic                m2_grant,
  output logic                m2_err,
  input  logic [N_SLAVES-1:0] s_ready,
  input  logic                s_done,
  output logic [N_SLAVES-1:0] s_en,
  output logic                owner,
  output logic                busy
);
  import bus_pkg::*;
  state_t state, nxt;
  mid_t win, nwin, pick, last_owner;
  logic [N_SLAVES-1:0] tgt, ntgt, oh1, oh2, psel;
  logic [1:0] lock, nlock, err, pbit, wbit;
  logic e1, e2, wreq, tc, rel;
  assign oh1  = N_SLAVES'(sel_onehot(m1_sel));
  assign oh2  = N_SLAVES'(sel_onehot(m2_sel));
  assign e1   = m1_req && !lock[0];
  assign e2   = m2_req && !lock[1];
  assign pick = (e1 && e2) ? (last_owner == M1 ? M2 : M1) : (e2 ? M2 : M1);
  assign psel = pick == M1 ? oh1 : oh2;
  assign pbit = pick == M1 ? 2'b01 : 2'b10;
  assign wbit = win == M1 ? 2'b01 : 2'b10;
  assign wreq = win == M1 ? m1_req : m2_req;
  arb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ctr (
    .clk(clk), .rstn(rstn), .clr(state != GRANT), .en(state == GRANT), .tc(tc)
  );
  // Request withdrawal outranks both ready and timeout; s_done outranks everything.
  always_comb begin
    nxt   = state;
    nwin  = win;
    ntgt  = tgt;
    err   = '0;
    rel   = 1'b0;
    nlock = lock & {m2_req, m1_req};
    case (state)
      IDLE: if (e1 || e2) begin
        nwin = pick;
        if (psel == '0) begin
          err   = pbit;
          nlock = nlock | pbit;
        end else begin
          ntgt = psel;
          nxt  = |(psel & s_ready) ? GRANT : WAIT;
        end
      end
      WAIT: nxt = !wreq ? TURN : (|(tgt & s_ready) ? GRANT : WAIT);
      GRANT: if (s_done || !wreq || tc) begin
        nxt = TURN;
        rel = 1'b1;
        if (!s_done && wreq) begin
          err   = wbit;
          nlock = nlock | wbit;
        end
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      state      <= IDLE;
      win        <= M1;
      tgt        <= '0;
      lock       <= '0;
      last_owner <= M2;
      m1_grant   <= 1'b0;
      m2_grant   <= 1'b0;
      m1_err     <= 1'b0;
      m2_err     <= 1'b0;
      s_en       <= '0;
      owner      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state    <= nxt;
      win      <= nwin;
      tgt      <= ntgt;
      lock     <= nlock;
      if (rel) last_owner <= win;
      m1_grant <= nxt == GRANT && nwin == M1;
      m2_grant <= nxt == GRANT && nwin == M2;
      m1_err   <= err[0];
      m2_err   <= err[1];
      s_en     <= nxt == GRANT ? ntgt : '0;
      busy     <= nxt == WAIT || nxt == GRANT;
      if (nxt == GRANT) owner <= nwin == M2;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter against a transaction-level model.
module tb_bus_arbiter;
  localparam int N = 3;
  localparam int T = 16;
  logic clk = 0, rstn = 0, m1_req = 0, m2_req = 0, s_done = 0;
  logic [3:0] m1_sel = 0, m2_sel = 0;
  logic [N-1:0] s_ready = 0;
  logic m1_grant, m1_err, m2_grant, m2_err, owner, busy;
  logic [N-1:0] s_en;
  int checks = 0, errors = 0;

  bus_arbiter #(.N_SLAVES(N), .SEL_W(4), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rstn(rstn),
    .m1_req(m1_req), .m1_sel(m1_sel), .m1_grant(m1_grant), .m1_err(m1_err),
    .m2_req(m2_req), .m2_sel(m2_sel), .m2_grant(m2_grant), .m2_err(m2_err),
    .s_ready(s_ready), .s_done(s_done), .s_en(s_en), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for slave, 2 owning bus, 3 turnaround.
  int ph = 0, who = 1, tgt = 1, held = 0, last = 2;
  bit lk [1:2];
  logic e_g1, e_g2, e_e1, e_e2, e_owner, e_busy;
  logic [N-1:0] e_sen;

  task automatic model_step();
    bit rq [1:2];
    int sl [1:2];
    bit er [1:2];
    bit a, b;
    int w;
    rq[1] = m1_req; rq[2] = m2_req;
    sl[1] = int'(m1_sel); sl[2] = int'(m2_sel);
    er[1] = 0; er[2] = 0;
    if (!rstn) begin
      ph = 0; who = 1; last = 2; lk[1] = 0; lk[2] = 0; e_owner = 0;
    end else begin
      for (int m = 1; m <= 2; m++) if (!rq[m]) lk[m] = 0;
      case (ph)
        0: begin
          a = rq[1] && !lk[1];
          b = rq[2] && !lk[2];
          if (a || b) begin
            w = (a && b) ? (last == 1 ? 2 : 1) : (a ? 1 : 2);
            if (sl[w] < 1 || sl[w] > N) begin
              er[w] = 1; lk[w] = 1;
            end else begin
              who = w; tgt = sl[w]; held = 0;
              ph = s_ready[tgt-1] ? 2 : 1;
            end
          end
        end
        1: if (!rq[who]) ph = 3; else if (s_ready[tgt-1]) begin ph = 2; held = 0; end
        2: begin
          held++;
          if (s_done || !rq[who]) begin ph = 3; last = who; end
          else if (held == T) begin ph = 3; last = who; er[who] = 1; lk[who] = 1; end
        end
        default: ph = 0;
      endcase
    end
    e_g1 = ph == 2 && who == 1;
    e_g2 = ph == 2 && who == 2;
    e_sen = ph == 2 ? N'(1 << (tgt - 1)) : '0;
    e_busy = ph == 1 || ph == 2;
    if (ph == 2) e_owner = (who == 2);
    e_e1 = er[1];
    e_e2 = er[2];
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("m1_grant", m1_grant, e_g1);
    chk("m2_grant", m2_grant, e_g2);
    chk("m1_err", m1_err, e_e1);
    chk("m2_err", m2_err, e_e2);
    chk("s_en", s_en, e_sen);
    chk("owner", owner, e_owner);
    chk("busy", busy, e_busy);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int gcnt, ecnt, errat;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    rstn = 1;
    // basic grant and release
    m1_sel = 1; s_ready = 3'b111; m1_req = 1;
    tick();
    chk("basic_grant", m1_grant, 1);
    chk("basic_sen", s_en, 3'b001);
    s_done = 1;
    tick();
    s_done = 0; m1_req = 0;
    chk("basic_rel", m1_grant, 0);
    chk("basic_busy", busy, 0);
    repeat (3) tick();
    // tie fairness from reset
    rstn = 0; tick(); rstn = 1;
    m1_sel = 1; m2_sel = 2; m1_req = 1; m2_req = 1;
    tick();
    chk("tie_m1", m1_grant, 1);
    chk("tie_m2_lo", m2_grant, 0);
    s_done = 1; tick(); s_done = 0;
    chk("tie_turn", m1_grant, 0);
    tick();
    chk("tie_idle", m2_grant, 0);
    tick();
    chk("tie_m2", m2_grant, 1);
    chk("tie_m2_sen", s_en, 3'b010);
    s_done = 1; tick(); s_done = 0;
    tick(); tick();
    chk("tie_back_m1", m1_grant, 1);
    m1_req = 0; m2_req = 0;
    repeat (3) tick();
    // invalid selects
    m2_sel = 0; m2_req = 1;
    tick();
    chk("inv0_err", m2_err, 1);
    chk("inv0_grant", m2_grant, 0);
    tick();
    chk("inv0_once", m2_err, 0);
    repeat (3) tick();
    chk("inv0_noretry", busy, 0);
    m2_req = 0; tick();
    m2_sel = 4'hA; m2_req = 1;
    tick();
    chk("invA_err", m2_err, 1);
    tick();
    chk("invA_once", m2_err, 0);
    m2_req = 0; tick();
    m2_sel = 2; m2_req = 1;
    tick();
    chk("inv_regrant", m2_grant, 1);
    chk("inv_sen", s_en, 3'b010);
    s_done = 1; m2_req = 0; tick(); s_done = 0;
    repeat (2) tick();
    // slave not ready
    s_ready = 3'b011; m1_sel = 3; m1_req = 1;
    tick();
    chk("nr_busy", busy, 1);
    chk("nr_nogrant", m1_grant, 0);
    m2_sel = 1; m2_req = 1;
    repeat (20) tick();
    chk("nr_busy20", busy, 1);
    chk("nr_m2_ign", m2_grant, 0);
    s_ready = 3'b111;
    tick();
    chk("nr_grant", m1_grant, 1);
    chk("nr_sen", s_en, 3'b100);
    s_done = 1; m1_req = 0; m2_req = 0; tick(); s_done = 0;
    repeat (2) tick();
    // timeout
    m1_sel = 1; m1_req = 1;
    tick();
    gcnt = 0; ecnt = 0; errat = -1;
    for (int i = 0; i < 40; i++) begin
      if (m1_grant) gcnt++;
      if (m1_err) begin ecnt++; errat = gcnt; end
      tick();
    end
    chk("to_len", gcnt, T);
    chk("to_errs", ecnt, 1);
    chk("to_errat", errat, T);
    m1_req = 0; tick(); tick();
    // s_done coinciding with timeout
    m1_req = 1;
    tick();
    repeat (15) tick();
    chk("to16_held", m1_grant, 1);
    s_done = 1; tick(); s_done = 0;
    chk("to16_rel", m1_grant, 0);
    chk("to16_noerr", m1_err, 0);
    m1_req = 0;
    tick();
    chk("to16_noerr2", m1_err, 0);
    repeat (2) tick();
    // reset mid-transfer
    m2_sel = 2; m2_req = 1;
    tick(); tick();
    chk("rm_owner1", owner, 1);
    rstn = 0; tick();
    chk("rm_grant", m2_grant, 0);
    chk("rm_owner0", owner, 0);
    chk("rm_sen", s_en, 0);
    rstn = 1; tick();
    chk("rm_regrant", m2_grant, 1);
    m2_req = 0; tick(); tick();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (m1_req) m1_req = ($urandom_range(0, 19) != 0);
      else if ($urandom_range(0, 3) == 0) begin
        m1_sel = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 4));
        m1_req = 1;
      end
      if (m2_req) m2_req = ($urandom_range(0, 19) != 0);
      else if ($urandom_range(0, 3) == 0) begin
        m2_sel = 4'($urandom_range(0, 4));
        m2_req = 1;
      end
      s_ready = N'($urandom);
      s_done = ($urandom_range(0, 23) == 0);
      rstn = ($urandom_range(0, 499) != 0);
      tick();
    end
    rstn = 1; s_done = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
